axi_mem_arbiter: RTL and testbench

Two-master to one-slave AXI4 arbiter that shares the single simulated DRAM memory port between two requesters, for example a core's memory port and a debug/DMA port. AR and AW are arbitrated independently with round-robin grants. W beats follow AW grant order through a route FIFO. R and B responses are steered back by an ID bit that the arbiter prepends to each request.

---
 rtl/axi_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// Two-requester to one-memory AXI4 arbiter: round-robin AR/AW, W ordered by AW grant, R/B steered by the prepended ID bit.
// Latency: zero, all request and response paths are combinational. Backpressure: ready mirrors the granted/addressed side; AW stalls while the W-route FIFO is full.

// Purpose: single-channel round-robin grant that holds its winner until the handshake completes.
// Latency: combinational select. Backpressure: block_i suppresses valid and both readies without disturbing the lock.
module axi_mem_arbiter_rr (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req_vld,
    input  logic       block,
    input  logic       m_rdy,
    output logic       sel,
    output logic       m_vld,
    output logic [1:0] s_rdy
);
    localparam logic IDLE   = 1'b0;
    localparam logic LOCKED = 1'b1;

    logic state_q, state_d;
    logic lock_q, lock_d;
    logic ptr_q, ptr_d;
    logic hs;

    always_comb begin
        if (state_q == LOCKED) sel = lock_q;
        else if (&req_vld)     sel = ptr_q;
        else                   sel = req_vld[1];
        m_vld = reset_n & ~block & req_vld[sel];
        s_rdy = 2'b00;
        if (reset_n && !block) s_rdy[sel] = m_rdy;
        hs = m_vld & m_rdy;
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        if (hs) begin
            state_d = IDLE;
            ptr_d   = ~sel;
        end else if (m_vld) begin
            // Keep the offered request stable on the memory side until accepted.
            state_d = LOCKED;
            lock_d  = sel;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// Purpose: small synchronous FIFO with registered count.
// Latency: pushed entry visible at head one cycle later. Backpressure: caller must not push when full or pop when empty.
module axi_mem_arbiter_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;

    assign head_dat = mem_q[rd_q];
    assign full     = (cnt_q == (PW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_dat;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// Purpose: top-level two-to-one AXI4 memory arbiter.
// Latency: zero on every channel. Backpressure: passes memory ready to the granted/addressed requester only.
module axi_mem_arbiter #(
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 64,
    parameter int STRB_BITS    = 8,
    parameter int S_ID_BITS    = 4,
    parameter int W_FIFO_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [1:0]               s_ar_valid,
    output logic [1:0]               s_ar_ready,
    input  logic [2*ADDR_BITS-1:0]   s_ar_addr,
    input  logic [2*S_ID_BITS-1:0]   s_ar_id,
    input  logic [5:0]               s_ar_size,
    input  logic [15:0]              s_ar_len,
    input  logic [1:0]               s_aw_valid,
    output logic [1:0]               s_aw_ready,
    input  logic [2*ADDR_BITS-1:0]   s_aw_addr,
    input  logic [2*S_ID_BITS-1:0]   s_aw_id,
    input  logic [5:0]               s_aw_size,
    input  logic [15:0]              s_aw_len,
    input  logic [1:0]               s_w_valid,
    output logic [1:0]               s_w_ready,
    input  logic [2*DATA_BITS-1:0]   s_w_data,
    input  logic [2*STRB_BITS-1:0]   s_w_strb,
    input  logic [1:0]               s_w_last,
    output logic [1:0]               s_r_valid,
    input  logic [1:0]               s_r_ready,
    output logic [DATA_BITS-1:0]     s_r_data,
    output logic [1:0]               s_r_resp,
    output logic [S_ID_BITS-1:0]     s_r_id,
    output logic                     s_r_last,
    output logic [1:0]               s_b_valid,
    input  logic [1:0]               s_b_ready,
    output logic [1:0]               s_b_resp,
    output logic [S_ID_BITS-1:0]     s_b_id,
    output logic                     m_ar_valid,
    input  logic                     m_ar_ready,
    output logic [ADDR_BITS-1:0]     m_ar_addr,
    output logic [S_ID_BITS:0]       m_ar_id,
    output logic [2:0]               m_ar_size,
    output logic [7:0]               m_ar_len,
    output logic                     m_aw_valid,
    input  logic                     m_aw_ready,
    output logic [ADDR_BITS-1:0]     m_aw_addr,
    output logic [S_ID_BITS:0]       m_aw_id,
    output logic [2:0]               m_aw_size,
    output logic [7:0]               m_aw_len,
    output logic                     m_w_valid,
    input  logic                     m_w_ready,
    output logic [DATA_BITS-1:0]     m_w_data,
    output logic [STRB_BITS-1:0]     m_w_strb,
    output logic                     m_w_last,
    input  logic                     m_r_valid,
    output logic                     m_r_ready,
    input  logic [DATA_BITS-1:0]     m_r_data,
    input  logic [1:0]               m_r_resp,
    input  logic [S_ID_BITS:0]       m_r_id,
    input  logic                     m_r_last,
    input  logic                     m_b_valid,
    output logic                     m_b_ready,
    input  logic [1:0]               m_b_resp,
    input  logic [S_ID_BITS:0]       m_b_id
);
    logic ar_sel, aw_sel;
    logic wq_full, wq_empty, wq_head, wq_push, wq_pop;
    logic w_en;
    logic r_sel, b_sel;

    axi_mem_arbiter_rr u_ar_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req_vld (s_ar_valid),
        .block   (1'b0),
        .m_rdy   (m_ar_ready),
        .sel     (ar_sel),
        .m_vld   (m_ar_valid),
        .s_rdy   (s_ar_ready)
    );

    // The full flag is registered, so a same-cycle W pop cannot reopen AW.
    axi_mem_arbiter_rr u_aw_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req_vld (s_aw_valid),
        .block   (wq_full),
        .m_rdy   (m_aw_ready),
        .sel     (aw_sel),
        .m_vld   (m_aw_valid),
        .s_rdy   (s_aw_ready)
    );

    assign m_ar_addr = ar_sel ? s_ar_addr[2*ADDR_BITS-1:ADDR_BITS] : s_ar_addr[ADDR_BITS-1:0];
    assign m_ar_id   = {ar_sel, ar_sel ? s_ar_id[2*S_ID_BITS-1:S_ID_BITS] : s_ar_id[S_ID_BITS-1:0]};
    assign m_ar_size = ar_sel ? s_ar_size[5:3] : s_ar_size[2:0];
    assign m_ar_len  = ar_sel ? s_ar_len[15:8] : s_ar_len[7:0];

    assign m_aw_addr = aw_sel ? s_aw_addr[2*ADDR_BITS-1:ADDR_BITS] : s_aw_addr[ADDR_BITS-1:0];
    assign m_aw_id   = {aw_sel, aw_sel ? s_aw_id[2*S_ID_BITS-1:S_ID_BITS] : s_aw_id[S_ID_BITS-1:0]};
    assign m_aw_size = aw_sel ? s_aw_size[5:3] : s_aw_size[2:0];
    assign m_aw_len  = aw_sel ? s_aw_len[15:8] : s_aw_len[7:0];

    assign wq_push = m_aw_valid & m_aw_ready;
    assign wq_pop  = m_w_valid & m_w_ready & m_w_last;

    axi_mem_arbiter_fifo #(
        .WIDTH (1),
        .DEPTH (W_FIFO_DEPTH)
    ) u_w_route (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (wq_push),
        .push_dat (aw_sel),
        .pop      (wq_pop),
        .head_dat (wq_head),
        .full     (wq_full),
        .empty    (wq_empty)
    );

    // W beats are only forwarded once their AW has been granted.
    assign w_en      = reset_n & ~wq_empty;
    assign m_w_valid = w_en & s_w_valid[wq_head];
    assign m_w_data  = wq_head ? s_w_data[2*DATA_BITS-1:DATA_BITS] : s_w_data[DATA_BITS-1:0];
    assign m_w_strb  = wq_head ? s_w_strb[2*STRB_BITS-1:STRB_BITS] : s_w_strb[STRB_BITS-1:0];
    assign m_w_last  = s_w_last[wq_head];

    assign r_sel = m_r_id[S_ID_BITS];
    assign b_sel = m_b_id[S_ID_BITS];

    always_comb begin
        s_w_ready = 2'b00;
        s_r_valid = 2'b00;
        s_b_valid = 2'b00;
        if (w_en)    s_w_ready[wq_head] = m_w_ready;
        if (reset_n) s_r_valid[r_sel]   = m_r_valid;
        if (reset_n) s_b_valid[b_sel]   = m_b_valid;
    end

    assign m_r_ready = reset_n & s_r_ready[r_sel];
    assign m_b_ready = reset_n & s_b_ready[b_sel];
    assign s_r_data  = m_r_data;
    assign s_r_resp  = m_r_resp;
    assign s_r_id    = m_r_id[S_ID_BITS-1:0];
    assign s_r_last  = m_r_last;
    assign s_b_resp  = m_b_resp;
    assign s_b_id    = m_b_id[S_ID_BITS-1:0];
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: arbitration order, grant locking, W ordering, FIFO-full gating, response steering, async reset.
module tb_axi_mem_arbiter;
    localparam int AB = 32;
    localparam int DB = 64;
    localparam int SB = 8;
    localparam int IB = 4;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [1:0]      s_ar_valid = '0, s_ar_ready;
    logic [2*AB-1:0] s_ar_addr = '0;
    logic [2*IB-1:0] s_ar_id = '0;
    logic [5:0]      s_ar_size = '0;
    logic [15:0]     s_ar_len = '0;
    logic [1:0]      s_aw_valid = '0, s_aw_ready;
    logic [2*AB-1:0] s_aw_addr = '0;
    logic [2*IB-1:0] s_aw_id = '0;
    logic [5:0]      s_aw_size = '0;
    logic [15:0]     s_aw_len = '0;
    logic [1:0]      s_w_valid = '0, s_w_ready;
    logic [2*DB-1:0] s_w_data = '0;
    logic [2*SB-1:0] s_w_strb = '0;
    logic [1:0]      s_w_last = '0;
    logic [1:0]      s_r_valid, s_r_ready = '0;
    logic [DB-1:0]   s_r_data;
    logic [1:0]      s_r_resp;
    logic [IB-1:0]   s_r_id;
    logic            s_r_last;
    logic [1:0]      s_b_valid, s_b_ready = '0;
    logic [1:0]      s_b_resp;
    logic [IB-1:0]   s_b_id;
    logic            m_ar_valid, m_ar_ready = 1'b0;
    logic [AB-1:0]   m_ar_addr;
    logic [IB:0]     m_ar_id;
    logic [2:0]      m_ar_size;
    logic [7:0]      m_ar_len;
    logic            m_aw_valid, m_aw_ready = 1'b0;
    logic [AB-1:0]   m_aw_addr;
    logic [IB:0]     m_aw_id;
    logic [2:0]      m_aw_size;
    logic [7:0]      m_aw_len;
    logic            m_w_valid, m_w_ready = 1'b0;
    logic [DB-1:0]   m_w_data;
    logic [SB-1:0]   m_w_strb;
    logic            m_w_last;
    logic            m_r_valid = 1'b0, m_r_ready;
    logic [DB-1:0]   m_r_data = '0;
    logic [1:0]      m_r_resp = '0;
    logic [IB:0]     m_r_id = '0;
    logic            m_r_last = 1'b0;
    logic            m_b_valid = 1'b0, m_b_ready;
    logic [1:0]      m_b_resp = '0;
    logic [IB:0]     m_b_id = '0;

    int n_chk = 0;
    int n_pass = 0;

    axi_mem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_ar_id(s_ar_id), .s_ar_size(s_ar_size), .s_ar_len(s_ar_len),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
        .s_aw_id(s_aw_id), .s_aw_size(s_aw_size), .s_aw_len(s_aw_len),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
        .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
        .s_r_resp(s_r_resp), .s_r_id(s_r_id), .s_r_last(s_r_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp), .s_b_id(s_b_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_id(m_ar_id), .m_ar_size(m_ar_size), .m_ar_len(m_ar_len),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr),
        .m_aw_id(m_aw_id), .m_aw_size(m_aw_size), .m_aw_len(m_aw_len),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data),
        .m_w_strb(m_w_strb), .m_w_last(m_w_last),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data),
        .m_r_resp(m_r_resp), .m_r_id(m_r_id), .m_r_last(m_r_last),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp), .m_b_id(m_b_id)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held with live stimulus: every handshake output must stay low.
        s_ar_valid = 2'b11; m_ar_ready = 1'b1; s_aw_valid = 2'b01; m_aw_ready = 1'b1;
        m_r_valid = 1'b1; s_r_ready = 2'b11; m_b_valid = 1'b1; s_b_ready = 2'b11;
        #3;
        chk("rst_m_ar_valid", m_ar_valid, 0);
        chk("rst_s_ar_ready", s_ar_ready, 0);
        chk("rst_m_aw_valid", m_aw_valid, 0);
        chk("rst_s_r_valid", s_r_valid, 0);
        chk("rst_m_r_ready", m_r_ready, 0);
        chk("rst_s_b_valid", s_b_valid, 0);
        chk("rst_m_b_ready", m_b_ready, 0);
        s_ar_valid = 0; m_ar_ready = 0; s_aw_valid = 0; m_aw_ready = 0;
        m_r_valid = 0; s_r_ready = 0; m_b_valid = 0; s_b_ready = 0;
        tick; tick;
        reset_n = 1'b1;

        // Single AR from requester 0.
        s_ar_addr = {32'h0000_2000, 32'h0000_1000};
        s_ar_id   = {4'h7, 4'h3};
        s_ar_len  = {8'h02, 8'h05};
        s_ar_size = {3'd2, 3'd3};
        s_ar_valid = 2'b01; m_ar_ready = 1'b1;
        #1;
        chk("ar0_valid", m_ar_valid, 1);
        chk("ar0_addr", m_ar_addr, 32'h1000);
        chk("ar0_id", m_ar_id, 5'h03);
        chk("ar0_len", m_ar_len, 8'h05);
        chk("ar0_size", m_ar_size, 3'd3);
        chk("ar0_ready", s_ar_ready, 2'b01);
        tick;

        // Both valid: pointer now favours requester 1, then alternates.
        s_ar_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ar_rr_id", m_ar_id, (k % 2 == 0) ? 5'h17 : 5'h03);
            chk("ar_rr_ready", s_ar_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick;
        end
        s_ar_valid = 2'b10;
        #1;
        chk("ar1_only_id", m_ar_id, 5'h17);
        tick;

        // Pointer favours requester 0 now, but a stalled requester 1 grant must hold.
        m_ar_ready = 1'b0;
        #1;
        chk("ar_lock_addr0", m_ar_addr, 32'h2000);
        chk("ar_lock_rdy0", s_ar_ready, 2'b00);
        tick;
        s_ar_valid = 2'b11;
        #1;
        chk("ar_lock_addr1", m_ar_addr, 32'h2000);
        tick;
        #1;
        chk("ar_lock_addr2", m_ar_addr, 32'h2000);
        chk("ar_lock_valid", m_ar_valid, 1);
        tick;
        m_ar_ready = 1'b1;
        #1;
        chk("ar_lock_hs_rdy", s_ar_ready, 2'b10);
        chk("ar_lock_hs_id", m_ar_id, 5'h17);
        tick;
        s_ar_valid = 2'b01;
        #1;
        chk("ar_after_lock_id", m_ar_id, 5'h03);
        tick;
        s_ar_valid = 0; m_ar_ready = 0;

        // AW req0 len=3, then AW req1 len=0; W must follow AW order.
        s_aw_addr = {32'h0000_0200, 32'h0000_0100};
        s_aw_id   = {4'h2, 4'h1};
        s_aw_len  = {8'h00, 8'h03};
        s_aw_valid = 2'b01; m_aw_ready = 1'b1;
        #1;
        chk("aw0_id", m_aw_id, 5'h01);
        chk("aw0_len", m_aw_len, 8'h03);
        chk("aw0_ready", s_aw_ready, 2'b01);
        tick;
        s_aw_valid = 2'b10;
        #1;
        chk("aw1_id", m_aw_id, 5'h12);
        chk("aw1_addr", m_aw_addr, 32'h200);
        chk("aw1_ready", s_aw_ready, 2'b10);
        tick;
        s_aw_valid = 0;
        m_w_ready = 1'b1;
        s_w_valid = 2'b10;
        s_w_data  = {64'hB1, 64'h0};
        s_w_strb  = {8'hF0, 8'h0F};
        s_w_last  = 2'b10;
        #1;
        chk("w1_early_valid", m_w_valid, 0);
        chk("w1_early_ready", s_w_ready[1], 0);
        tick;
        s_w_valid = 2'b11;
        for (int b = 0; b < 4; b++) begin
            s_w_data[63:0] = 64'hA0 + 64'(b);
            s_w_last[0] = (b == 3);
            #1;
            chk("w0_data", m_w_data, 64'hA0 + 64'(b));
            chk("w0_last", m_w_last, (b == 3) ? 1 : 0);
            chk("w0_ready", s_w_ready, 2'b01);
            tick;
        end
        #1;
        chk("w1_valid", m_w_valid, 1);
        chk("w1_data", m_w_data, 64'hB1);
        chk("w1_strb", m_w_strb, 8'hF0);
        chk("w1_ready", s_w_ready, 2'b10);
        tick;
        #1;
        chk("w_empty_valid", m_w_valid, 0);
        chk("w_empty_ready", s_w_ready, 2'b00);
        s_w_valid = 0; s_w_last = 0; m_w_ready = 0;

        // Fill the W-route FIFO with W withheld.
        s_aw_valid = 2'b01; m_aw_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("fill_aw_ready", s_aw_ready, 2'b01);
            tick;
        end
        #1;
        chk("full_m_aw_valid", m_aw_valid, 0);
        chk("full_s_aw_ready", s_aw_ready, 2'b00);
        tick;
        s_w_valid = 2'b01; s_w_last = 2'b01; m_w_ready = 1'b1;
        #1;
        chk("full_pop_w_valid", m_w_valid, 1);
        chk("full_pop_same_cyc", m_aw_valid, 0);
        tick;
        s_w_valid = 0; s_w_last = 0; m_w_ready = 0;
        #1;
        chk("after_pop_aw_valid", m_aw_valid, 1);
        chk("after_pop_aw_ready", s_aw_ready, 2'b01);
        s_aw_valid = 0;
        tick;

        // R and B steering by the prepended ID bit.
        m_r_id = 5'h15; m_r_valid = 1'b1; m_r_data = 64'hDEAD_BEEF; m_r_last = 1'b1; m_r_resp = 2'b10;
        s_r_ready = 2'b00;
        #1;
        chk("r_valid", s_r_valid, 2'b10);
        chk("r_id", s_r_id, 4'h5);
        chk("r_ready_none", m_r_ready, 0);
        chk("r_data", s_r_data, 64'hDEAD_BEEF);
        chk("r_resp", s_r_resp, 2'b10);
        s_r_ready = 2'b01;
        #1;
        chk("r_ready_wrong", m_r_ready, 0);
        s_r_ready = 2'b10;
        #1;
        chk("r_ready_right", m_r_ready, 1);
        m_b_id = 5'h02; m_b_valid = 1'b1; m_b_resp = 2'b01; s_b_ready = 2'b01;
        #1;
        chk("b_valid", s_b_valid, 2'b01);
        chk("b_id", s_b_id, 4'h2);
        chk("b_resp", s_b_resp, 2'b01);
        chk("b_ready", m_b_ready, 1);

        // Asynchronous reset in the middle of a cycle.
        s_ar_valid = 2'b01; m_ar_ready = 1'b1; s_aw_valid = 2'b01; m_aw_ready = 1'b1;
        s_w_valid = 2'b01; s_w_last = 2'b01; m_w_ready = 1'b1;
        #1;
        chk("pre_rst_ar_valid", m_ar_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_m_ar_valid", m_ar_valid, 0);
        chk("arst_m_aw_valid", m_aw_valid, 0);
        chk("arst_m_w_valid", m_w_valid, 0);
        chk("arst_s_ar_ready", s_ar_ready, 0);
        chk("arst_s_aw_ready", s_aw_ready, 0);
        chk("arst_s_w_ready", s_w_ready, 0);
        chk("arst_s_r_valid", s_r_valid, 0);
        chk("arst_m_r_ready", m_r_ready, 0);
        chk("arst_s_b_valid", s_b_valid, 0);
        chk("arst_m_b_ready", m_b_ready, 0);
        tick;
        reset_n = 1'b1;
        #1;
        chk("post_rst_w_empty", m_w_valid, 0);
        chk("post_rst_aw_open", m_aw_valid, 1);
        chk("post_rst_ar_id", m_ar_id, 5'h03);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
